// File: rtl/sort_result_streamer_if.sv
// ---------------------------------------------------------------------------
// sort_result_streamer_if
// Valid/ready element stream carrying one sorted element per transfer.
//   out_valid  : element on out_data is valid           (master -> slave)
//   out_ready  : downstream can accept                   (slave  -> master)
//   out_data   : current element                         (master -> slave)
//   out_index  : position of out_data within the frame   (master -> slave)
//   out_last   : high with the final element of a frame  (master -> slave)
// ---------------------------------------------------------------------------
interface sort_result_streamer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH-1:0] out_index;
    logic                  out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_index,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_index,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/sort_result_streamer.sv
// ---------------------------------------------------------------------------
// sort_result_streamer
// Snapshots a sorted frame from the sorter into a shadow bank on the rising
// edge of `done`, then streams it out one element per valid/ready transfer,
// index 0 first. Ascending order is checked on the fly, and frames that
// arrive while a previous one is still in flight are flagged and dropped.
//
// Ports:
//   clk          : rising-edge clock
//   reset        : asynchronous active-low reset
//   done         : sorter completion level (only rising edges start a frame)
//   sorted_array : sorted frame, valid from the cycle after done rises
//   stream       : valid/ready output stream (master modport)
//   busy         : high while arming or streaming
//   order_error  : sticky until next arm, frame held a descending pair
//   overrun      : sticky until reset, done rose while busy
//   frame_count  : completed frames, wraps at 16 bits
// ---------------------------------------------------------------------------
module sort_result_streamer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  done,
    input  logic [DATA_WIDTH-1:0] sorted_array [0:(1<<ADDR_WIDTH)-1],
    sort_result_streamer_if.master stream,
    output logic                  busy,
    output logic                  order_error,
    output logic                  overrun,
    output logic [15:0]           frame_count
);
    localparam int N = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] IDX_ZERO = '0;
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] IDX_LAST = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t                state_r;
    state_t                state_next_s;
    logic                  done_q_r;
    logic                  done_rise_s;
    logic                  transfer_s;
    logic                  last_xfer_s;
    logic                  capture_s;
    logic                  busy_next_s;
    logic [ADDR_WIDTH-1:0] index_next_s;

    logic [DATA_WIDTH-1:0] shadow_r [0:N-1];
    logic [ADDR_WIDTH-1:0] index_r;
    logic [DATA_WIDTH-1:0] prev_elem_r;
    logic                  out_valid_r;
    logic [DATA_WIDTH-1:0] out_data_r;
    logic [ADDR_WIDTH-1:0] out_index_r;
    logic                  out_last_r;
    logic                  busy_r;
    logic                  order_error_r;
    logic                  overrun_r;
    logic [15:0]           frame_count_r;

    assign done_rise_s  = done & ~done_q_r;
    // out_valid_r is only ever high in STREAM, so a transfer implies STREAM.
    assign transfer_s   = out_valid_r & stream.out_ready;
    assign last_xfer_s  = transfer_s & (index_r == IDX_LAST);
    assign index_next_s = index_r + IDX_ONE;

    assign stream.out_valid = out_valid_r;
    assign stream.out_data  = out_data_r;
    assign stream.out_index = out_index_r;
    assign stream.out_last  = out_last_r;
    assign busy             = busy_r;
    assign order_error      = order_error_r;
    assign overrun          = overrun_r;
    assign frame_count      = frame_count_r;

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (done_rise_s) begin
                    state_next_s = ARM;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ARM: begin
                state_next_s = STREAM;
            end
            STREAM: begin
                if (last_xfer_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = STREAM;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM output decode: capture strobe and next busy level
    always_comb begin
        capture_s   = 1'b0;
        busy_next_s = 1'b0;
        case (state_r)
            IDLE: begin
                capture_s = 1'b0;
            end
            ARM: begin
                // The sorter output is registered, so the frame is only
                // stable one cycle after the done edge: sample it here.
                capture_s = 1'b1;
            end
            STREAM: begin
                capture_s = 1'b0;
            end
            default: begin
                capture_s = 1'b0;
            end
        endcase
        if (state_next_s != IDLE) begin
            busy_next_s = 1'b1;
        end else begin
            busy_next_s = 1'b0;
        end
    end

    // Done edge detector and busy flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_q_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            done_q_r <= done;
            busy_r   <= busy_next_s;
        end
    end

    // Shadow bank: frozen at arm so later sorter changes cannot leak in
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                shadow_r[i] <= '0;
            end
        end else if (capture_s) begin
            for (int i = 0; i < N; i++) begin
                shadow_r[i] <= sorted_array[i];
            end
        end
    end

    // Stream output registers, index walk and frame counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            index_r       <= IDX_ZERO;
            out_valid_r   <= 1'b0;
            out_data_r    <= '0;
            out_index_r   <= IDX_ZERO;
            out_last_r    <= 1'b0;
            frame_count_r <= 16'd0;
        end else if (capture_s) begin
            // First element comes straight from the input so it is
            // presented the cycle after arm, not one later.
            index_r     <= IDX_ZERO;
            out_valid_r <= 1'b1;
            out_data_r  <= sorted_array[0];
            out_index_r <= IDX_ZERO;
            out_last_r  <= 1'b0;
        end else if (last_xfer_s) begin
            index_r       <= IDX_ZERO;
            out_valid_r   <= 1'b0;
            out_data_r    <= '0;
            out_index_r   <= IDX_ZERO;
            out_last_r    <= 1'b0;
            frame_count_r <= frame_count_r + 16'd1;
        end else if (transfer_s) begin
            index_r     <= index_next_s;
            out_data_r  <= shadow_r[index_next_s];
            out_index_r <= index_next_s;
            out_last_r  <= (index_next_s == IDX_LAST);
        end
    end

    // Running ascending-order check over transferred elements
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_elem_r   <= '0;
            order_error_r <= 1'b0;
        end else if (capture_s) begin
            order_error_r <= 1'b0;
        end else if (transfer_s) begin
            prev_elem_r <= shadow_r[index_r];
            if ((index_r != IDX_ZERO) && (shadow_r[index_r] < prev_elem_r)) begin
                order_error_r <= 1'b1;
            end
        end
    end

    // Overrun: a new frame edge while one is in flight is dropped and flagged
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun_r <= 1'b0;
        end else if (done_rise_s && (state_r != IDLE)) begin
            overrun_r <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sort_result_streamer.sv
// ---------------------------------------------------------------------------
// tb_sort_result_streamer
// Table-driven bench: each row describes one frame (data, ready pattern,
// done timing) plus its expected order-error position and overrun. A
// hand-written sequence covers reset in the middle of a stream.
// ---------------------------------------------------------------------------
module tb_sort_result_streamer;
    logic       clk;
    logic       reset;
    logic       done;
    logic [7:0] sorted_array [0:15];
    logic       busy;
    logic       order_error;
    logic       overrun;
    logic [15:0] frame_count;

    sort_result_streamer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) sif ();

    sort_result_streamer #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .done         (done),
        .sorted_array (sorted_array),
        .stream       (sif.master),
        .busy         (busy),
        .order_error  (order_error),
        .overrun      (overrun),
        .frame_count  (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ready_pat;  // ready level indexed by cycle % 8
        int         oe_idx;     // index whose transfer raises order_error, -1 none
        int         hold;       // cycles done stays high from the start
        int         pulse_at;   // element index at which an extra done pulse starts, -1 none
        int         pulse_len;  // length of that pulse in cycles
        logic       exp_ov;     // frame is expected to raise overrun
    } vec_t;

    vec_t       tbl      [9];
    logic [7:0] tbl_data [9][16];
    logic [7:0] exp_d    [16];

    int   errors = 0;
    int   checks = 0;
    int   fc_exp = 0;
    logic ov_exp = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_row(input int r, input logic [7:0] pat, input int oe, input int hold,
                           input int pat_at, input int plen, input logic ov);
        tbl[r].ready_pat = pat;
        tbl[r].oe_idx    = oe;
        tbl[r].hold      = hold;
        tbl[r].pulse_at  = pat_at;
        tbl[r].pulse_len = plen;
        tbl[r].exp_ov    = ov;
    endtask

    task automatic run_frame(input int r);
        int   cyc;
        int   k;
        int   pstart;
        int   extra;
        logic started;
        logic rdy;
        cyc     = 0;
        k       = 0;
        pstart  = 0;
        started = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_d[i]        = tbl_data[r][i];
            sorted_array[i] = tbl_data[r][i];
        end
        sif.out_ready = 1'b0;
        done = 1'b1;
        step; cyc++;
        chk($sformatf("r%0d arm_valid", r), sif.out_valid, 1'b0);
        chk($sformatf("r%0d arm_busy", r), busy, 1'b1);
        done = (cyc < tbl[r].hold);
        step; cyc++;
        // Sorter output changes after arm must not reach the stream.
        for (int i = 0; i < 16; i++) sorted_array[i] = ~exp_d[i];
        while (k < 16 && cyc < 300) begin
            chk($sformatf("r%0d k%0d valid", r, k), sif.out_valid, 1'b1);
            chk($sformatf("r%0d k%0d data", r, k), sif.out_data, exp_d[k]);
            chk($sformatf("r%0d k%0d index", r, k), sif.out_index, k);
            chk($sformatf("r%0d k%0d last", r, k), sif.out_last, (k == 15));
            chk($sformatf("r%0d k%0d order_err", r, k), order_error,
                (tbl[r].oe_idx >= 0) && (k > tbl[r].oe_idx));
            chk($sformatf("r%0d k%0d fcount", r, k), frame_count, fc_exp);
            chk($sformatf("r%0d k%0d busy", r, k), busy, 1'b1);
            if (!started && k == tbl[r].pulse_at) begin
                started = 1'b1;
                pstart  = cyc;
            end
            done = (cyc < tbl[r].hold) || (started && cyc < pstart + tbl[r].pulse_len);
            rdy  = tbl[r].ready_pat[cyc % 8];
            sif.out_ready = rdy;
            if (rdy) k++;
            step; cyc++;
        end
        if (k < 16) chk($sformatf("r%0d stream_timeout", r), 32'(k), 32'd16);
        fc_exp = (fc_exp + 1) % 65536;
        ov_exp = ov_exp | tbl[r].exp_ov;
        extra  = 0;
        for (int n = 0; n < 100 && (done || extra < 3); n++) begin
            chk($sformatf("r%0d post valid", r), sif.out_valid, 1'b0);
            chk($sformatf("r%0d post busy", r), busy, 1'b0);
            chk($sformatf("r%0d post fcount", r), frame_count, fc_exp);
            chk($sformatf("r%0d post order_err", r), order_error, (tbl[r].oe_idx >= 0));
            chk($sformatf("r%0d post overrun", r), overrun, ov_exp);
            done = (cyc < tbl[r].hold) || (started && cyc < pstart + tbl[r].pulse_len);
            if (!done) extra++;
            step; cyc++;
        end
        sif.out_ready = 1'b0;
    endtask

    initial begin
        // Row table
        for (int i = 0; i < 16; i++) begin
            tbl_data[0][i] = 8'(i);
            tbl_data[1][i] = 8'(i);
            tbl_data[2][i] = (i < 5) ? 8'd0 : 8'(i + 3);
            tbl_data[3][i] = 8'(i * 16 + 1);
            tbl_data[4][i] = 8'(i);
            tbl_data[5][i] = 8'(15 - i);
            tbl_data[6][i] = 8'(i);
            tbl_data[7][i] = 8'(i);
            tbl_data[8][i] = 8'(i * 2);
        end
        tbl_data[2][0] = 8'd3;
        tbl_data[2][1] = 8'd5;
        tbl_data[2][2] = 8'd5;
        tbl_data[2][3] = 8'd2;
        tbl_data[2][4] = 8'd7;
        set_row(0, 8'hFF,        -1,  1, -1, 0, 1'b0); // plain frame, full rate
        set_row(1, 8'b0101_1001, -1,  1, -1, 0, 1'b0); // stalls 1,0,0,1,...
        set_row(2, 8'hFF,         3,  1, -1, 0, 1'b0); // descending pair at 3
        set_row(3, 8'b1011_0111, -1,  1, -1, 0, 1'b0); // clean frame clears error
        set_row(4, 8'hFF,        -1, 40, -1, 0, 1'b0); // done held 40 cycles
        set_row(5, 8'hFF,         1,  1, -1, 0, 1'b0); // reversed frame
        set_row(6, 8'hFF,        -1,  1,  6, 1, 1'b1); // done pulse mid-stream
        set_row(7, 8'hFF,        -1,  1, -1, 0, 1'b0); // full frame after reset
        set_row(8, 8'hFF,        -1,  1, 15, 5, 1'b1); // rise with final transfer

        reset = 1'b0;
        done  = 1'b0;
        sif.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) sorted_array[i] = 8'd0;
        step; step;
        chk("rst valid", sif.out_valid, 1'b0);
        chk("rst data", sif.out_data, 8'd0);
        chk("rst index", sif.out_index, 4'd0);
        chk("rst last", sif.out_last, 1'b0);
        chk("rst busy", busy, 1'b0);
        chk("rst order_err", order_error, 1'b0);
        chk("rst overrun", overrun, 1'b0);
        chk("rst fcount", frame_count, 16'd0);
        reset = 1'b1;
        step;

        for (int r = 0; r < 7; r++) run_frame(r);

        // Reset asserted while element 9 is being presented.
        for (int i = 0; i < 16; i++) sorted_array[i] = 8'(i + 100);
        done = 1'b1;
        step;
        done = 1'b0;
        step;
        sif.out_ready = 1'b1;
        for (int n = 0; n < 40 && sif.out_index != 4'd9; n++) step;
        chk("midrst pre index", sif.out_index, 4'd9);
        chk("midrst pre data", sif.out_data, 8'd109);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst valid", sif.out_valid, 1'b0);
        chk("midrst data", sif.out_data, 8'd0);
        chk("midrst index", sif.out_index, 4'd0);
        chk("midrst busy", busy, 1'b0);
        chk("midrst overrun", overrun, 1'b0);
        chk("midrst fcount", frame_count, 16'd0);
        sif.out_ready = 1'b0;
        step;
        reset  = 1'b1;
        fc_exp = 0;
        ov_exp = 1'b0;
        step;
        chk("midrst idle valid", sif.out_valid, 1'b0);

        for (int r = 7; r < 9; r++) run_frame(r);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
